// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core load/store port and a debug/loader port.
// The core has priority. A starved debug request is forced through after MAX_WAIT lost cycles.
module dmem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              sys_rst,
   input  logic              cpu_re,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_raddr,
   input  logic [ADDR_W-1:0] cpu_waddr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   input  logic              dbg_halt,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_re,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

   logic [3:0] wait_cnt;
   logic       cpu_act;
   logic       force_dbg;
   logic       cpu_own;
   logic       dbg_own;

   assign cpu_act   = cpu_re | cpu_we;
   assign force_dbg = dbg_req & (dbg_halt | (wait_cnt == MAX_CNT));
   assign cpu_rdata = mem_rdata;

   // Halt without a debug request leaves the memory idle while still stalling the core.
   always_comb begin
      cpu_own   = 1'b0;
      dbg_own   = 1'b0;
      cpu_stall = 1'b0;
      if (sys_rst) begin
         cpu_own = 1'b0;
      end else if (force_dbg) begin
         dbg_own   = 1'b1;
         cpu_stall = cpu_act;
      end else if (dbg_halt) begin
         cpu_stall = cpu_act;
      end else if (cpu_act) begin
         cpu_own = 1'b1;
      end else if (dbg_req) begin
         dbg_own = 1'b1;
      end
   end

   always_comb begin
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_raddr = '0;
      mem_waddr = '0;
      mem_wdata = '0;
      dbg_gnt   = 1'b0;
      if (cpu_own) begin
         mem_re    = cpu_re;
         mem_we    = cpu_we;
         mem_raddr = cpu_raddr;
         mem_waddr = cpu_waddr;
         mem_wdata = cpu_wdata;
      end else if (dbg_own) begin
         mem_re    = ~dbg_we;
         mem_we    = dbg_we;
         mem_raddr = dbg_addr;
         mem_waddr = dbg_addr;
         mem_wdata = dbg_wdata;
         dbg_gnt   = 1'b1;
      end
   end

   // The wait count restarts whenever debug is served or withdraws its request.
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         wait_cnt   <= '0;
         dbg_rvalid <= 1'b0;
         dbg_rdata  <= '0;
      end else begin
         if (dbg_gnt || !dbg_req) begin
            wait_cnt <= '0;
         end else if (wait_cnt < MAX_CNT) begin
            wait_cnt <= wait_cnt + 4'd1;
         end
         dbg_rvalid <= dbg_gnt & ~dbg_we;
         if (dbg_gnt && !dbg_we) begin
            dbg_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed cycles push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_dmem_arbiter;

   logic        clk;
   logic        sys_rst;
   logic        cpu_re, cpu_we;
   logic [31:0] cpu_raddr, cpu_waddr, cpu_wdata, cpu_rdata;
   logic        cpu_stall;
   logic        dbg_req, dbg_we, dbg_halt, dbg_gnt, dbg_rvalid;
   logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic        mem_re, mem_we;
   logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;

   logic [31:0] mem [0:255];

   typedef struct {
      string       name;
      logic        gnt, stall, re, we, rvalid;
      logic [31:0] raddr, waddr, wdata, rdata, cpu_rd;
   } exp_t;

   exp_t exp_q[$];
   int   vectors    = 0;
   int   miscompares = 0;

   localparam logic [31:0] M0 = 32'h1000_0000;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
      .clk(clk), .sys_rst(sys_rst),
      .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_raddr(cpu_raddr), .cpu_waddr(cpu_waddr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_halt(dbg_halt), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_re(mem_re), .mem_we(mem_we), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: combinational read, write on the rising edge.
   assign mem_rdata = mem[mem_raddr[7:0]];
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = M0 + 32'(i);
      forever begin
         @(posedge clk);
         if (mem_we) mem[mem_waddr[7:0]] <= mem_wdata;
      end
   end

   task automatic setCpu(input logic re, input logic we, input logic [31:0] raddr,
                         input logic [31:0] waddr, input logic [31:0] wdata);
      cpu_re = re; cpu_we = we; cpu_raddr = raddr; cpu_waddr = waddr; cpu_wdata = wdata;
   endtask

   task automatic setDbg(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic halt);
      dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_halt = halt;
   endtask

   task automatic applyStimulus(input string name, input logic gnt, input logic stall,
                                input logic re, input logic we, input logic [31:0] raddr,
                                input logic [31:0] waddr, input logic [31:0] wdata,
                                input logic rvalid, input logic [31:0] rdata,
                                input logic [31:0] cpu_rd);
      exp_t e;
      e.name = name; e.gnt = gnt; e.stall = stall; e.re = re; e.we = we;
      e.raddr = raddr; e.waddr = waddr; e.wdata = wdata; e.rvalid = rvalid;
      e.rdata = rdata; e.cpu_rd = cpu_rd;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input exp_t e);
      bit bad = 0;
      vectors++;
      if (dbg_gnt !== e.gnt) begin
         $display("[TB] FAIL %s dbg_gnt got %b want %b", e.name, dbg_gnt, e.gnt); bad = 1;
      end
      if (cpu_stall !== e.stall) begin
         $display("[TB] FAIL %s cpu_stall got %b want %b", e.name, cpu_stall, e.stall); bad = 1;
      end
      if (mem_re !== e.re || mem_we !== e.we) begin
         $display("[TB] FAIL %s re/we got %b%b want %b%b", e.name, mem_re, mem_we, e.re, e.we);
         bad = 1;
      end
      if (mem_raddr !== e.raddr || mem_waddr !== e.waddr || mem_wdata !== e.wdata) begin
         $display("[TB] FAIL %s raddr/waddr/wdata got %h/%h/%h want %h/%h/%h", e.name,
                  mem_raddr, mem_waddr, mem_wdata, e.raddr, e.waddr, e.wdata);
         bad = 1;
      end
      if (dbg_rvalid !== e.rvalid || dbg_rdata !== e.rdata) begin
         $display("[TB] FAIL %s rvalid/rdata got %b/%h want %b/%h", e.name,
                  dbg_rvalid, dbg_rdata, e.rvalid, e.rdata);
         bad = 1;
      end
      if (cpu_rdata !== e.cpu_rd) begin
         $display("[TB] FAIL %s cpu_rdata got %h want %h", e.name, cpu_rdata, e.cpu_rd);
         bad = 1;
      end
      if (bad) miscompares++;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
      end
   end

   initial begin
      sys_rst = 1'b1;
      setCpu(0, 1, 32'h0, 32'h20, 32'h5);
      setDbg(1, 0, 32'h10, 32'h0, 0);
      @(posedge clk);
      #1;
      applyStimulus("reset0", 0,0,0,0, 0,0,0, 0,0, M0);
      applyStimulus("reset1", 0,0,0,0, 0,0,0, 0,0, M0);

      sys_rst = 1'b0;
      setCpu(0, 0, 0, 0, 0);
      setDbg(0, 0, 0, 0, 0);
      applyStimulus("idle", 0,0,0,0, 0,0,0, 0,0, M0);

      setDbg(1, 1, 32'h10, 32'hDEAD_BEEF, 0);
      applyStimulus("dbg_wr", 1,0,0,1, 32'h10,32'h10,32'hDEAD_BEEF, 0,0, M0 + 32'h10);
      setDbg(1, 0, 32'h10, 32'h0, 0);
      applyStimulus("dbg_rd", 1,0,1,0, 32'h10,32'h10,0, 0,0, 32'hDEAD_BEEF);
      setDbg(0, 0, 32'h10, 32'h0, 0);
      applyStimulus("dbg_rv", 0,0,0,0, 0,0,0, 1,32'hDEAD_BEEF, M0);

      setCpu(1, 1, 32'h10, 32'h20, 32'h7);
      applyStimulus("cpu_pass", 0,0,1,1, 32'h10,32'h20,32'h7, 0,32'hDEAD_BEEF, 32'hDEAD_BEEF);

      // Core reads every cycle; debug read raised at cycle 0 must be forced at cycle 4.
      setCpu(1, 0, 32'h20, 32'h20, 32'h7);
      setDbg(1, 0, 32'h30, 32'h0, 0);
      for (int i = 0; i < 4; i++)
         applyStimulus($sformatf("starve%0d", i), 0,0,1,0, 32'h20,32'h20,32'h7,
                       0,32'hDEAD_BEEF, 32'h7);
      applyStimulus("starve4", 1,1,1,0, 32'h30,32'h30,0, 0,32'hDEAD_BEEF, M0 + 32'h30);
      setDbg(0, 0, 32'h30, 32'h0, 0);
      applyStimulus("starve5", 0,0,1,0, 32'h20,32'h20,32'h7, 1,M0 + 32'h30, 32'h7);

      // Withdrawing the request for one cycle restarts the wait.
      for (int i = 0; i < 8; i++) begin
         setDbg((i == 3) ? 1'b0 : 1'b1, 1, 32'h40, 32'h55, 0);
         applyStimulus($sformatf("wdraw%0d", i), 0,0,1,0, 32'h20,32'h20,32'h7,
                       0,M0 + 32'h30, 32'h7);
      end
      applyStimulus("wdraw8", 1,1,0,1, 32'h40,32'h40,32'h55, 0,M0 + 32'h30, M0 + 32'h40);
      setDbg(0, 0, 32'h0, 32'h0, 0);
      applyStimulus("wdraw9", 0,0,1,0, 32'h20,32'h20,32'h7, 0,M0 + 32'h30, 32'h7);

      // Halt with the core writing 0x50 every cycle and debug issuing three reads.
      setCpu(1, 1, 32'h20, 32'h50, 32'h99);
      setDbg(1, 0, 32'h40, 0, 1);
      applyStimulus("halt0", 1,1,1,0, 32'h40,32'h40,0, 0,M0 + 32'h30, 32'h55);
      setDbg(0, 0, 32'h40, 0, 1);
      applyStimulus("halt1", 0,1,0,0, 0,0,0, 1,32'h55, M0);
      setDbg(1, 0, 32'h10, 0, 1);
      applyStimulus("halt2", 1,1,1,0, 32'h10,32'h10,0, 0,32'h55, 32'hDEAD_BEEF);
      setDbg(0, 0, 32'h10, 0, 1);
      applyStimulus("halt3", 0,1,0,0, 0,0,0, 1,32'hDEAD_BEEF, M0);
      setDbg(1, 0, 32'h50, 0, 1);
      applyStimulus("halt4", 1,1,1,0, 32'h50,32'h50,0, 0,32'hDEAD_BEEF, M0 + 32'h50);
      setDbg(0, 0, 32'h50, 0, 1);
      applyStimulus("halt5", 0,1,0,0, 0,0,0, 1,M0 + 32'h50, M0);
      for (int i = 6; i < 10; i++)
         applyStimulus($sformatf("halt%0d", i), 0,1,0,0, 0,0,0, 0,M0 + 32'h50, M0);

      setDbg(0, 0, 0, 0, 0);
      applyStimulus("resume_wr", 0,0,1,1, 32'h20,32'h50,32'h99, 0,M0 + 32'h50, 32'h7);
      setCpu(1, 0, 32'h50, 32'h50, 32'h99);
      applyStimulus("resume_rd", 0,0,1,0, 32'h50,32'h50,32'h99, 0,M0 + 32'h50, 32'h99);
      setCpu(0, 0, 0, 0, 0);
      applyStimulus("final_idle", 0,0,0,0, 0,0,0, 0,M0 + 32'h50, M0);

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         $display("[TB] FAIL drain pending got %0d want 0", exp_q.size());
         miscompares++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
